// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit bitwise logic unit (AND/OR/NOR/INV)
// among NUM_REQ requesters. Each operation runs GRANT -> EXEC -> DONE, and the
// result comes back with a one-cycle valid pulse tagged with the owner's index.
module logic_unit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [2*NUM_REQ-1:0]    opcode,
   input  logic [32*NUM_REQ-1:0]   op_a,
   input  logic [32*NUM_REQ-1:0]   op_b,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [31:0]             result,
   output logic                    valid,
   output logic [ID_W-1:0]         res_id,
   output logic                    busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_EXEC  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_reg, state_next;

   // Arbitration state: pointer to last winner and the winner being granted
   logic [ID_W-1:0]     ptr_reg;
   logic [ID_W-1:0]     win_reg;
   logic [ID_W-1:0]     win_next;
   logic                win_found;

   // Operands captured at the end of the grant cycle
   logic [1:0]          opc_reg;
   logic [31:0]         a_reg;
   logic [31:0]         b_reg;
   logic [ID_W-1:0]     id_reg;

   // Registered outputs
   logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
   logic                valid_reg, valid_next;
   logic                busy_reg, busy_next;
   logic [31:0]         result_reg;
   logic [ID_W-1:0]     res_id_reg;
   logic [31:0]         alu_out;

   // Per-requester views of the flattened request buses
   logic [1:0]          opc_arr [NUM_REQ];
   logic [31:0]         a_arr   [NUM_REQ];
   logic [31:0]         b_arr   [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign opc_arr[gi] = opcode[2*gi +: 2];
         assign a_arr[gi]   = op_a[32*gi +: 32];
         assign b_arr[gi]   = op_b[32*gi +: 32];
      end
   endgenerate

   // Round-robin search starting just after the last winner, so the last
   // winner is always considered last
   always_comb begin
      win_next  = '0;
      win_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!win_found && req[(int'(ptr_reg) + k) % NUM_REQ]) begin
            win_found = 1'b1;
            win_next  = ID_W'((int'(ptr_reg) + k) % NUM_REQ);
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; DONE loops straight back to GRANT for back-to-back work
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (|req) state_next = S_GRANT;
         S_GRANT: state_next = S_EXEC;
         S_EXEC:  state_next = S_DONE;
         S_DONE:  state_next = (|req) ? S_GRANT : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Output decode on the upcoming state so the flops line up with it
   always_comb begin
      gnt_next   = '0;
      valid_next = 1'b0;
      busy_next  = (state_next != S_IDLE);
      if (state_next == S_GRANT) begin
         gnt_next[win_next] = 1'b1;
      end
      if (state_next == S_DONE) begin
         valid_next = 1'b1;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_reg   <= '0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         gnt_reg   <= gnt_next;
         valid_reg <= valid_next;
         busy_reg  <= busy_next;
      end
   end

   // Bitwise logic unit working on the captured operands
   always_comb begin
      case (opc_reg)
         2'b00:   alu_out = a_reg & b_reg;
         2'b01:   alu_out = a_reg | b_reg;
         2'b10:   alu_out = ~(a_reg | b_reg);
         default: alu_out = ~a_reg;
      endcase
   end

   // Winner capture, operand latch at the end of GRANT, result at the end of EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg    <= ID_W'(NUM_REQ - 1);
         win_reg    <= '0;
         opc_reg    <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         id_reg     <= '0;
         result_reg <= '0;
         res_id_reg <= '0;
      end else begin
         if (state_next == S_GRANT) begin
            win_reg <= win_next;
         end
         if (state_reg == S_GRANT) begin
            opc_reg <= opc_arr[win_reg];
            a_reg   <= a_arr[win_reg];
            b_reg   <= b_arr[win_reg];
            id_reg  <= win_reg;
            ptr_reg <= win_reg;
         end
         if (state_reg == S_EXEC) begin
            result_reg <= alu_out;
            res_id_reg <= id_reg;
         end
      end
   end

   assign gnt    = gnt_reg;
   assign valid  = valid_reg;
   assign busy   = busy_reg;
   assign result = result_reg;
   assign res_id = res_id_reg;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: stimulus pushes expected grants and
// results into queues, and a negedge monitor pops and compares them.
module tb_logic_unit_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                   clk;
   logic                   rst;
   logic [NUM_REQ-1:0]     req;
   logic [2*NUM_REQ-1:0]   opcode;
   logic [32*NUM_REQ-1:0]  op_a;
   logic [32*NUM_REQ-1:0]  op_b;
   logic [NUM_REQ-1:0]     gnt;
   logic [31:0]            result;
   logic                   valid;
   logic [ID_W-1:0]        res_id;
   logic                   busy;

   int vectors;
   int miscompares;
   int cyc;
   int last_gnt_cyc;

   logic [NUM_REQ-1:0]     exp_gnt_q [$];
   logic [33:0]            exp_res_q [$];
   int                     gnt_cyc_q [$];

   logic_unit_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .opcode (opcode),
      .op_a   (op_a),
      .op_b   (op_b),
      .gnt    (gnt),
      .result (result),
      .valid  (valid),
      .res_id (res_id),
      .busy   (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %h (cycle %0d)", name, act, cyc);
      end
   endtask

   // Monitor: every grant and every valid pulse is matched against the queues
   always @(negedge clk) begin
      logic [NUM_REQ-1:0] eg;
      logic [33:0]        er;
      if (!rst) begin
         if (gnt != '0) begin
            chk("gnt_onehot_novalid", {62'd0, $onehot(gnt), valid}, 64'd2);
            if (exp_gnt_q.size() == 0) begin
               chk("unexpected_gnt", {60'd0, gnt}, 64'd0);
            end else begin
               eg = exp_gnt_q.pop_front();
               chk("gnt", {60'd0, gnt}, {60'd0, eg});
            end
            last_gnt_cyc = cyc;
            gnt_cyc_q.push_back(cyc);
         end
         if (valid) begin
            if (exp_res_q.size() == 0) begin
               chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
               er = exp_res_q.pop_front();
               chk("result", {32'd0, result}, {32'd0, er[31:0]});
               chk("res_id", {62'd0, res_id}, {62'd0, er[33:32]});
               chk("valid_latency", 64'(cyc - last_gnt_cyc), 64'd2);
            end
         end
      end
   end

   task automatic set_req(input int id, input logic [1:0] opc,
                          input logic [31:0] a, input logic [31:0] b);
      opcode[2*id +: 2] = opc;
      op_a[32*id +: 32] = a;
      op_b[32*id +: 32] = b;
      req[id]           = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("idle_reached", {63'd0, busy}, 64'd0);
   endtask

   // Single operation; the requester drops REQ in its grant cycle
   task automatic do_op(input int id, input logic [1:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int  n;
      bit  seen;
      logic [NUM_REQ-1:0] g;
      g = '0;
      g[id] = 1'b1;
      exp_gnt_q.push_back(g);
      exp_res_q.push_back({2'(id), exp});
      set_req(id, opc, a, b);
      seen = 0;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gnt[id]) begin
            seen = 1;
            break;
         end
      end
      chk("gnt_seen", {63'd0, seen}, 64'd1);
      req[id] = 1'b0;
      seen = 0;
      for (n = 0; n < 10; n++) begin
         @(negedge clk);
         if (valid) begin
            seen = 1;
            break;
         end
      end
      chk("valid_seen", {63'd0, seen}, 64'd1);
      @(negedge clk);
      chk("busy_fall", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int n;
      int cnt;
      vectors      = 0;
      miscompares  = 0;
      cyc          = 0;
      last_gnt_cyc = 0;
      rst    = 1'b1;
      req    = '0;
      opcode = '0;
      op_a   = '0;
      op_b   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", {24'd0, gnt, valid, result, res_id, busy}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset asserted during EXEC discards the operation
      exp_gnt_q.push_back(4'b0001);
      set_req(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      req = '0;
      @(negedge clk);
      chk("in_exec_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", {24'd0, gnt, valid, result, res_id, busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_reset_busy", {63'd0, busy}, 64'd0);

      // Single op on requester 2
      do_op(2, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);

      // Remaining opcodes on requester 0
      do_op(0, 2'b01, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
      do_op(0, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F);
      do_op(0, 2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0F0F_0F0F);

      // Requester 3 wins alone, leaving ptr=3
      do_op(3, 2'b11, 32'h1234_5678, 32'h0000_0000, 32'hEDCB_A987);

      // All four held: order 0,1,2,3,0, three cycles apart
      gnt_cyc_q.delete();
      exp_gnt_q.push_back(4'b0001);
      exp_gnt_q.push_back(4'b0010);
      exp_gnt_q.push_back(4'b0100);
      exp_gnt_q.push_back(4'b1000);
      exp_gnt_q.push_back(4'b0001);
      exp_res_q.push_back({2'd0, 32'h0A0A_0505});
      exp_res_q.push_back({2'd1, 32'h1234_5678});
      exp_res_q.push_back({2'd2, 32'h0000_FFFF});
      exp_res_q.push_back({2'd3, 32'h0000_0000});
      exp_res_q.push_back({2'd0, 32'h0A0A_0505});
      set_req(0, 2'b00, 32'hAAAA_5555, 32'h0F0F_0F0F);
      set_req(1, 2'b01, 32'h1234_0000, 32'h0000_5678);
      set_req(2, 2'b10, 32'h0000_0000, 32'hFFFF_0000);
      set_req(3, 2'b11, 32'hFFFF_FFFF, 32'h1234_5678);
      cnt = 0;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (gnt != '0) cnt++;
         if (cnt == 5) break;
      end
      req = '0;
      chk("rr_grant_count", 64'(cnt), 64'd5);
      wait_idle();
      if (gnt_cyc_q.size() == 5) begin
         for (int i = 0; i < 4; i++) begin
            chk("gnt_spacing", 64'(gnt_cyc_q[i+1] - gnt_cyc_q[i]), 64'd3);
         end
      end else begin
         chk("gnt_spacing_count", 64'(gnt_cyc_q.size()), 64'd5);
      end

      // Requester 1 wins to leave ptr=1, then 3 and 1 contend: 3 goes first
      do_op(1, 2'b00, 32'hFFFF_FFFF, 32'h1357_2468, 32'h1357_2468);
      exp_gnt_q.push_back(4'b1000);
      exp_gnt_q.push_back(4'b0010);
      exp_res_q.push_back({2'd3, 32'hFFFF_FFFF});
      exp_res_q.push_back({2'd1, 32'hFFFF_0000});
      set_req(3, 2'b01, 32'h0000_FFFF, 32'hFFFF_0000);
      set_req(1, 2'b10, 32'h0000_FFFF, 32'h0000_FF00);
      for (n = 0; n < 30; n++) begin
         @(negedge clk);
         if (gnt[3]) req[3] = 1'b0;
         if (gnt[1]) req[1] = 1'b0;
         if (req == '0) break;
      end
      chk("contend_req_served", {60'd0, req}, 64'd0);
      wait_idle();

      // Everything expected must have been consumed
      repeat (5) @(negedge clk);
      chk("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'd0);
      chk("res_queue_empty", 64'(exp_res_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
